// File: rtl/kgp_mem_arbiter.sv
// kgp_mem_arbiter: shares one single-port BRAM between fetch and load/store.
// Define KGP_ARB_ALIGN_CHK_EN to reject misaligned data accesses with d_err.
module kgp_mem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_AW    = 10,
    parameter int MEM_LAT   = 2,
    parameter int MAX_D_RUN = 4
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int RW = $clog2(MAX_D_RUN + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
    logic [RW-1:0]     run_cnt_q, run_cnt_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] rdata_q, if_rdata_q, d_rdata_q;
    logic              st_vld_q, err_q;
    logic              if_win, d_win, d_mis, d_issue;
    logic              unused_addr;

    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (reset && state_q == IDLE) begin
            if_win = if_req && (!d_req || run_cnt_q == RW'(MAX_D_RUN));
            d_win  = d_req && !if_win;
        end
    end

`ifdef KGP_ARB_ALIGN_CHK_EN
    assign d_mis = d_win && (d_addr[1:0] != 2'b00);
`else
    assign d_mis = 1'b0;
`endif
    assign d_issue = d_win && !d_mis;

    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign mem_en    = if_win || d_issue;
    assign mem_we    = d_issue && d_we;
    assign mem_wdata = reset ? d_wdata : '0;
    assign busy      = (state_q != IDLE);

    always_comb begin
        mem_addr = '0;
        if (d_win)
            mem_addr = d_addr[MEM_AW+1:2];
        else if (if_win)
            mem_addr = if_addr[MEM_AW+1:2];
    end

    // RESP presents the captured word directly; the hold registers catch up at its end.
    assign if_valid = (state_q == RESP) && !owner_q;
    assign d_valid  = st_vld_q || ((state_q == RESP) && owner_q);
    assign d_err    = err_q;
    assign if_rdata = if_valid ? rdata_q : if_rdata_q;
    assign d_rdata  = ((state_q == RESP) && owner_q) ? rdata_q : d_rdata_q;

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        run_cnt_d = run_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (if_win || (d_issue && !d_we)) begin
                    state_d   = RD_WAIT;
                    lat_cnt_d = LW'(1);
                    owner_d   = d_win;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == LW'(MEM_LAT)) begin
                    state_d   = RESP;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!if_req || if_win)
            run_cnt_d = '0;
        else if (d_win)
            run_cnt_d = run_cnt_q + 1'b1;
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            run_cnt_q  <= '0;
            owner_q    <= 1'b0;
            rdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            st_vld_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            run_cnt_q <= run_cnt_d;
            owner_q   <= owner_d;
            st_vld_q  <= d_win && (d_we || d_mis);
            err_q     <= d_mis;
            if (state_q == RD_WAIT && lat_cnt_q == LW'(MEM_LAT))
                rdata_q <= mem_rdata;
            if (state_q == RESP) begin
                if (owner_q)
                    d_rdata_q <= rdata_q;
                else
                    if_rdata_q <= rdata_q;
            end
        end
    end

    assign unused_addr = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                           d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

endmodule

// File: tb/tb_kgp_mem_arbiter.sv
// Random scoreboard bench for kgp_mem_arbiter (MEM_LAT=2, MAX_D_RUN=4).
// Expected responses are queued at grant time and popped by a separate monitor.
module tb_kgp_mem_arbiter;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAW  = 10;
    localparam int LAT  = 2;
    localparam int MAXR = 4;
    localparam int NW   = 1 << MAW;

    typedef struct {
        int          kind;  // 0 read, 1 store, 2 rejected
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           if_req, if_gnt, if_valid;
    logic [AW-1:0]  if_addr;
    logic [DW-1:0]  if_rdata;
    logic           d_req, d_we, d_gnt, d_valid, d_err;
    logic [AW-1:0]  d_addr;
    logic [DW-1:0]  d_wdata, d_rdata;
    logic           mem_en, mem_we, busy;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata, mem_rdata;

    kgp_mem_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_AW(MAW),
        .MEM_LAT(LAT), .MAX_D_RUN(MAXR)
    ) dut (
        .clka(clk), .reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] bram [NW];
    logic [DW-1:0] rd_pipe [LAT];
    bit            init_done = 1'b0;
    exp_t          if_q[$];
    exp_t          d_q[$];
    int            mode = 0;
    int            errors = 0;
    int            checks = 0;

    assign mem_rdata = rd_pipe[LAT-1];

    // BRAM with LAT-cycle registered read
    initial begin
        wait (init_done);
        for (int i = 0; i < NW; i++) bram[i] = ref_mem[i];
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
            rd_pipe[0] <= bram[mem_addr];
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    task automatic chk(input string n, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, act, exp);
        end
    endtask

    // monitor-side reference state
    int            free_at = 0;
    int            streak = 0;
    logic [DW-1:0] last_if = '0;
    logic [DW-1:0] last_d = '0;
    bit            final_done = 1'b0;

    task automatic check_zero();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_err", d_err, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic check_cycle();
        bit   free, eif, ed, mis, eiv, edv;
        exp_t e;
        free = (cyc >= free_at);
        eif  = free && if_req && (!d_req || streak == MAXR);
        ed   = free && d_req && !eif;
`ifdef KGP_ARB_ALIGN_CHK_EN
        mis = ed && (d_addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        chk("if_gnt", if_gnt, eif);
        chk("d_gnt", d_gnt, ed);
        chk("busy", busy, !free);
        chk("mem_en", mem_en, eif || (ed && !mis));
        if (eif) chk("mem_addr_if", mem_addr, if_addr[MAW+1:2]);
        if (ed && !mis) begin
            chk("mem_addr_d", mem_addr, d_addr[MAW+1:2]);
            chk("mem_we", mem_we, d_we);
            if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
        end
        if (eif) begin
            free_at = cyc + LAT + 2;
            streak  = 0;
        end else if (ed) begin
            if (!d_we && !mis) free_at = cyc + LAT + 2;
            streak++;
        end
        if (!if_req) streak = 0;

        eiv = (if_q.size() != 0) && (if_q[0].cyc == cyc);
        chk("if_valid", if_valid, eiv);
        if (eiv) begin
            e = if_q.pop_front();
            last_if = e.data;
        end
        chk("if_rdata", if_rdata, last_if);

        edv = (d_q.size() != 0) && (d_q[0].cyc == cyc);
        chk("d_valid", d_valid, edv);
        if (edv) begin
            e = d_q.pop_front();
            chk("d_err", d_err, e.kind == 2);
            if (e.kind == 0) last_d = e.data;
        end
        chk("d_rdata", d_rdata, last_d);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                1: check_zero();
                2: begin
                    chk("dir_if_gnt", if_gnt, 1);
                    chk("dir_mem_en", mem_en, 1);
                    chk("dir_mem_addr", mem_addr, 2);
                    chk("dir_busy", busy, 0);
                end
                3: begin
                    chk("post_rst_if_valid", if_valid, 0);
                    chk("post_rst_busy", busy, 0);
                    chk("post_rst_if_rdata", if_rdata, 0);
                end
                4: check_cycle();
                5: if (!final_done) begin
                    chk("final_if_q", if_q.size(), 0);
                    chk("final_d_q", d_q.size(), 0);
                    chk("final_req_pending", {if_req, d_req}, 0);
                    chk("final_busy", busy, 0);
                    final_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [DW-1:0] last_ld = '0;

    task automatic step(input bit allow);
        bit             ig, dg, mis;
        logic [MAW-1:0] idx;
        @(negedge clk);
        ig = if_req && if_gnt;
        dg = d_req && d_gnt;
        if (ig)
            if_q.push_back(exp_t'{kind: 0, data: ref_mem[if_addr[MAW+1:2]],
                                  cyc: cyc + LAT + 1});
        if (dg) begin
            idx = d_addr[MAW+1:2];
`ifdef KGP_ARB_ALIGN_CHK_EN
            mis = (d_addr[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            if (mis) begin
                d_q.push_back(exp_t'{kind: 2, data: last_ld, cyc: cyc + 1});
            end else if (d_we) begin
                ref_mem[idx] = d_wdata;
                d_q.push_back(exp_t'{kind: 1, data: d_wdata, cyc: cyc + 1});
            end else begin
                last_ld = ref_mem[idx];
                d_q.push_back(exp_t'{kind: 0, data: last_ld, cyc: cyc + LAT + 1});
            end
        end
        @(posedge clk);
        #1;
        if (ig) if_req = 1'b0;
        if (dg) d_req = 1'b0;
        if (allow && !if_req && $urandom_range(0, 2) != 0) begin
            if_req  = 1'b1;
            if_addr = $urandom;
        end
        if (allow && !d_req && $urandom_range(0, 7) != 0) begin
            d_req   = 1'b1;
            d_we    = ($urandom_range(0, 2) != 0);
            d_addr  = $urandom;
            if ($urandom_range(0, 5) != 0) d_addr[1:0] = 2'b00;
            d_wdata = $urandom;
        end
    endtask

    initial begin
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        rst_n   = 1'b0;
        mode    = 1;
        for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
        init_done = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mode = 0;
        @(posedge clk);
        #1 if_req = 1'b1;
        if_addr = 32'h8;
        mode = 2;
        @(posedge clk);
        #1 if_req = 1'b0;
        mode = 0;
        #2 rst_n = 1'b0;
        mode = 1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mode = 3;
        repeat (6) @(posedge clk);
        #1 mode = 4;
        for (int c = 0; c < 3000; c++) step(1'b1);
        for (int c = 0; c < 100; c++) begin
            if (!if_req && !d_req && if_q.size() == 0 && d_q.size() == 0) break;
            step(1'b0);
        end
        mode = 5;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kgp_mem_arbiter.md
Name: kgp_mem_arbiter

Overview:
- Shares one single-port instruction/data BRAM between the KGP_RISC fetch stage and the load/store stage.
- Arbitrates between the two requesters and sequences the fixed-latency memory read.
- Returns data to the requester whose access won arbitration.
- Sits between the processor top level and the memory IP; runs on the processor clock.

Parameters:
- DATA_W, 32, data width of all data ports.
- ADDR_W, 32, byte-address width of requester ports.
- MEM_AW, 10, word-address width of memory. mem_addr = addr[MEM_AW+1:2].
- MEM_LAT, 2, BRAM read latency in cycles. Legal range 1..4.
- MAX_D_RUN, 4, maximum consecutive data grants while if_req is pending.

Ports:
- clka  in  1  processor clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle pulse: load data valid, or store complete.
- d_err  out  1  error flag qualified by d_valid.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_AW  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- States and outputs:
  - FSM states: IDLE, RD_WAIT, RESP.
  - Counters: lat_cnt (0..MEM_LAT), run_cnt (0..MAX_D_RUN).
  - Registers: owner (0 = fetch, 1 = data), rdata_q.
- Reset (reset low, async, including mid-operation):
  - State goes to IDLE; lat_cnt, run_cnt and owner go to 0.
  - All outputs go to 0, including if_rdata, d_rdata and rdata_q.
  - Any in-flight read is dropped; no valid pulse follows release.
- Requester rules:
  - Requesters hold req, addr, we and wdata stable until their gnt.
  - gnt is combinational, asserted only in IDLE, and at most one gnt per cycle.
- IDLE arbitration in grant cycle T:
  - Default priority is data over fetch.
  - If if_req=1, d_req=1 and run_cnt==MAX_D_RUN, fetch wins.
  - run_cnt increments on a data grant while if_req=1.
  - run_cnt clears on a fetch grant, or on any cycle with if_req=0.
- Memory drive:
  - In the grant cycle, mem_en=1, mem_addr comes from the winner's address, and mem_we = d_we for a data winner.
  - mem_wdata = d_wdata.
  - mem_en=0 in all other cycles.
- Store granted at T:
  - Memory writes at edge T.
  - d_valid=1 in cycle T+1, d_err=0.
  - FSM stays in IDLE, so a new grant is possible in T+1.
- Load or fetch granted at T:
  - Go to RD_WAIT with lat_cnt=1.
  - Increment lat_cnt each cycle.
  - When lat_cnt==MEM_LAT, capture mem_rdata into rdata_q and go to RESP.
  - In RESP (cycle T+MEM_LAT+1), drive the owner's rdata=rdata_q and valid=1 for one cycle.
  - Go to IDLE; arbitration in that IDLE cycle is allowed.
  - Read throughput is one read per MEM_LAT+2 cycles.
- Output hold: rdata outputs hold their last value between valid pulses.
- Address handling:
  - addr[1:0] is ignored (word access).
  - Bits above MEM_AW+1 are truncated, so addresses wrap modulo memory size.
- Requests arriving in RD_WAIT or RESP wait; no gnt, no loss.
- busy = (state != IDLE).

Optional Feature:
- Macro: KGP_ARB_ALIGN_CHK_EN.
- Defined:
  - A data request with d_addr[1:0] != 0 is still granted and consumes its grant slot.
  - It is not issued to memory: mem_en=0 that cycle.
  - d_valid=1, d_err=1 and d_rdata unchanged in cycle T+1; the FSM stays in IDLE.
  - Fetch requests are never checked.
- Undefined: d_err is tied to 0 and misaligned addresses are silently word-aligned.

Test Plan (MEM_LAT=2, MAX_D_RUN=4):
- Reset mid-read: fetch if_addr=0x8 granted, then reset low for 1 cycle at T+1 -> all outputs 0, no if_valid ever pulses, busy=0 after release.
- Single fetch: mem[2]=0xDEADBEEF, if_req with if_addr=0x8 at T -> if_gnt at T, mem_addr=2 at T, if_valid=1 with if_rdata=0xDEADBEEF at T+3, busy=1 during T+1..T+3.
- Collision: if_req and d_req (load, d_addr=0x10, mem[4]=0x1234) both at T -> d_gnt at T, d_valid with d_rdata=0x1234 at T+3, if_gnt at T+4.
- Store then load: store 0xCAFEF00D to 0x20 at T -> mem_we=1, mem_addr=8 at T, d_valid=1 at T+1; load 0x20 granted at T+1 -> d_rdata=0xCAFEF00D at T+4.
- Starvation: if_req held high, d_req stores back-to-back -> exactly 4 consecutive d_gnt, then if_gnt, then run_cnt resets.
- Macro on: store to d_addr=0x22 -> mem_en=0, d_valid=1 and d_err=1 next cycle, memory unchanged. Macro off: same store writes word 8, d_err=0.
